sid_i2s_tx: RTL and testbench



---
 rtl/sid_i2s_tx.sv | 170 +++++++++++++++++
 tb/tb_sid_i2s_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx
// ----------
// Serialises the signed 16-bit SID mix into an I2S frame for an external DAC.
// Samples arrive over a valid/ready handshake into a small FIFO. One word is
// popped per frame and sent as mono, duplicated on left and right. BCLK and
// LRCLK free-run from CLK.
//
// Optional feature macro: SID_I2S_HOLD_EN
//   defined   -> an underrun repeats the last popped word (0 if none yet)
//   undefined -> an underrun sends silence (0)
//
// Parameters
//   CLK_DIV      CLK cycles per BCLK half-period (>= 2)
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW
// Ports
//   CLK          master clock
//   RST          asynchronous active-high reset
//   SAMPLE       signed 16-bit audio sample
//   SAMPLE_VALID SAMPLE is presented this cycle
//   SAMPLE_READY FIFO not full (registered)
//   I2S_BCLK     bit clock
//   I2S_LRCLK    word select, 0 = left, 1 = right
//   I2S_DATA     serial data, MSB first, one BCLK behind LRCLK
//   UNDERRUN     one-cycle pulse when a frame load finds the FIFO empty

module sid_i2s_tx #(
    parameter int CLK_DIV = 6,
    parameter int FIFO_AW = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [15:0] SAMPLE,
    input  logic               SAMPLE_VALID,
    output logic               SAMPLE_READY,
    output logic               I2S_BCLK,
    output logic               I2S_LRCLK,
    output logic               I2S_DATA,
    output logic               UNDERRUN
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic               bclk_q, bclk_d;
    logic [4:0]         slot_q, slot_d;
    logic               lrclk_q, lrclk_d;
    logic [31:0]        shift_q, shift_d;
    logic               data_q, data_d;
    logic               underrun_q, underrun_d;
    logic [15:0]        lastWord_q, lastWord_d;
    logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d;
    logic [FIFO_AW-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic [15:0]        mem_q [DEPTH];

    logic        divTick;
    logic        fallTick;
    logic        frameLoad;
    logic        fifoEmpty;
    logic        pushEn;
    logic        popEn;
    logic [15:0] headWord;
    logic [15:0] fillWord;
    logic [15:0] loadWord;

    // Event decode: the divider wrap toggles BCLK, a wrap while BCLK is high
    // is a falling tick, and the falling tick leaving slot 0 is the frame load.
    // Pushes are gated by the registered READY, so a full FIFO never accepts.
    always_comb begin
        divTick   = (divCnt_q == DIV_LAST);
        fallTick  = divTick && bclk_q;
        frameLoad = fallTick && (slot_q == 5'd0);
        fifoEmpty = (count_q == '0);
        pushEn    = SAMPLE_VALID && ready_q;
        popEn     = frameLoad && !fifoEmpty;
        headWord  = mem_q[rdPtr_q];
`ifdef SID_I2S_HOLD_EN
        fillWord  = lastWord_q;
`else
        fillWord  = 16'h0000;
`endif
        loadWord  = popEn ? headWord : fillWord;
    end

    // Next-state logic for the timebase, serialiser and FIFO bookkeeping.
    // At a frame load the MSB goes straight to the data register and the
    // shift register keeps the remaining 31 bits of {W, W}. The right-channel
    // LSB therefore leaves on slot 0 of the next frame, giving the I2S
    // one-BCLK delay. A pop on an empty FIFO is not counted, so a push in
    // the same cycle stays queued for the next frame.
    always_comb begin
        divCnt_d   = divTick ? '0 : divCnt_q + DIV_W'(1);
        bclk_d     = divTick ? ~bclk_q : bclk_q;
        slot_d     = fallTick ? slot_q + 5'd1 : slot_q;
        lrclk_d    = fallTick ? slot_d[4] : lrclk_q;
        shift_d    = shift_q;
        data_d     = data_q;
        if (frameLoad) begin
            data_d  = loadWord[15];
            shift_d = {loadWord[14:0], loadWord, 1'b0};
        end else if (fallTick) begin
            data_d  = shift_q[31];
            shift_d = {shift_q[30:0], 1'b0};
        end
        underrun_d = frameLoad && fifoEmpty;
        lastWord_d = popEn ? headWord : lastWord_q;
        wrPtr_d    = pushEn ? wrPtr_q + FIFO_AW'(1) : wrPtr_q;
        rdPtr_d    = popEn ? rdPtr_q + FIFO_AW'(1) : rdPtr_q;
        count_d    = count_q;
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d    = (count_d != CNT_FULL);
    end

    // All architectural state, cleared asynchronously. The divider restarts
    // at 0 with BCLK low, so the first rising tick is CLK_DIV cycles after
    // release and the first frame load is 2*CLK_DIV cycles after release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            divCnt_q   <= '0;
            bclk_q     <= 1'b0;
            slot_q     <= 5'd0;
            lrclk_q    <= 1'b0;
            shift_q    <= 32'h0;
            data_q     <= 1'b0;
            underrun_q <= 1'b0;
            lastWord_q <= 16'h0000;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
        end else begin
            divCnt_q   <= divCnt_d;
            bclk_q     <= bclk_d;
            slot_q     <= slot_d;
            lrclk_q    <= lrclk_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
            lastWord_q <= lastWord_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
        end
    end

    // FIFO storage. It has no reset: an empty count hides whatever the
    // entries hold, and a word is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= SAMPLE;
        end
    end

    assign SAMPLE_READY = ready_q;
    assign I2S_BCLK     = bclk_q;
    assign I2S_LRCLK    = lrclk_q;
    assign I2S_DATA     = data_q;
    assign UNDERRUN     = underrun_q;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb_sid_i2s_tx
// -------------
// Bench for sid_i2s_tx. The main instance runs with CLK_DIV=2 to keep frames
// short. A second instance with CLK_DIV=6 is fed continuously and is used
// for the rate and timebase figures. Build with +define+SID_I2S_HOLD_EN to
// exercise the hold-on-underrun variant.

module tb_sid_i2s_tx;

    localparam int D     = 2;
    localparam int DR    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 64 * D;

    logic        CLK = 1'b0;
    logic        rst;
    logic        rstRate;
    logic [15:0] sample;
    logic        sampleValid;
    logic        rdy, bclk, lrclk, dataOut, under;
    logic        rdyR, bclkR, lrclkR, dataR, underR;

    int total;
    int bad;

    sid_i2s_tx #(.CLK_DIV(D), .FIFO_AW(AW)) dut (
        .CLK(CLK), .RST(rst), .SAMPLE(sample), .SAMPLE_VALID(sampleValid),
        .SAMPLE_READY(rdy), .I2S_BCLK(bclk), .I2S_LRCLK(lrclk),
        .I2S_DATA(dataOut), .UNDERRUN(under)
    );

    sid_i2s_tx #(.CLK_DIV(DR), .FIFO_AW(AW)) dutRate (
        .CLK(CLK), .RST(rstRate), .SAMPLE(16'hA5C3), .SAMPLE_VALID(1'b1),
        .SAMPLE_READY(rdyR), .I2S_BCLK(bclkR), .I2S_LRCLK(lrclkR),
        .I2S_DATA(dataR), .UNDERRUN(underR)
    );

    always #5 CLK = ~CLK;

    // Queue-level view of the transmitter: one frame load every 64*D cycles,
    // starting 2*D cycles after release. A load takes the oldest queued
    // sample or the fill word. A push is accepted when the queue held fewer
    // than DEPTH entries after the previous cycle.
    int          nCyc;
    logic [15:0] mq[$];
    bit          mReady;
    logic [15:0] mLast;
    logic [15:0] mW;
    bit          mAcc;
    logic [15:0] expWords[$];
    int          expUnder[$];

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            nCyc   = 0;
            mq.delete();
            mReady = 1'b1;
            mLast  = 16'h0000;
            expWords.delete();
            expUnder.delete();
        end else begin
            nCyc = nCyc + 1;
            mAcc = sampleValid && mReady;
            if (nCyc >= 2 * D && ((nCyc - 2 * D) % FRAME) == 0) begin
                if (mq.size() > 0) begin
                    mW    = mq.pop_front();
                    mLast = mW;
                end else begin
`ifdef SID_I2S_HOLD_EN
                    mW = mLast;
`else
                    mW = 16'h0000;
`endif
                    expUnder.push_back(nCyc);
                end
                expWords.push_back(mW);
            end
            if (mAcc) mq.push_back(sample);
            mReady = (mq.size() < DEPTH);
        end
    end

    // Receiver for the main instance: data is captured on every BCLK rise.
    // Rise k (k >= 1) falls in slot (k-1) mod 32, so rises 2..33 of each
    // frame hold {left, right}.
    int          rc;
    logic [31:0] cap;
    logic [31:0] gotWords[$];
    int          gotUnder[$];
    int          lrErr;
    int          stabErr;
    logic        prevB, prevD, expLr;

    always @(negedge CLK) begin
        if (rst) begin
            rc      = 0;
            cap     = 32'h0;
            gotWords.delete();
            gotUnder.delete();
            lrErr   = 0;
            stabErr = 0;
            prevB   = 1'b0;
            prevD   = 1'b0;
        end else begin
            if (under === 1'b1) gotUnder.push_back(nCyc);
            if (prevB === 1'b0 && bclk === 1'b1) begin
                rc = rc + 1;
                if (dataOut !== prevD) stabErr = stabErr + 1;
                cap   = {cap[30:0], dataOut};
                expLr = (((rc - 1) % 32) >= 16);
                if (lrclk !== expLr) lrErr = lrErr + 1;
                if (rc >= 33 && ((rc - 33) % 32) == 0) gotWords.push_back(cap);
            end
            prevB = bclk;
            prevD = dataOut;
        end
    end

    // Timebase measurements on the CLK_DIV=6 instance.
    int   rCyc, rLastB, rLastL, rFirstB, rFirstL;
    int   rBErr, rLErr, rStab, rBCnt, rLCnt, rUnder;
    logic rPrevB, rPrevL, rPrevD;

    always @(negedge CLK) begin
        if (rstRate) begin
            rCyc = 0; rLastB = -1; rLastL = -1; rFirstB = -1; rFirstL = -1;
            rBErr = 0; rLErr = 0; rStab = 0; rBCnt = 0; rLCnt = 0; rUnder = 0;
            rPrevB = 1'b0; rPrevL = 1'b0; rPrevD = 1'b0;
        end else begin
            rCyc = rCyc + 1;
            if (underR === 1'b1) rUnder = rUnder + 1;
            if (rPrevB === 1'b0 && bclkR === 1'b1) begin
                if (rLastB >= 0 && (rCyc - rLastB) != 2 * DR) rBErr = rBErr + 1;
                if (rFirstB < 0) rFirstB = rCyc;
                if (dataR !== rPrevD) rStab = rStab + 1;
                rLastB = rCyc;
                rBCnt  = rBCnt + 1;
            end
            if (rPrevL === 1'b0 && lrclkR === 1'b1) begin
                if (rLastL >= 0 && (rCyc - rLastL) != 64 * DR) rLErr = rLErr + 1;
                if (rFirstL < 0) rFirstL = rCyc;
                rLastL = rCyc;
                rLCnt  = rLCnt + 1;
            end
            rPrevB = bclkR;
            rPrevL = lrclkR;
            rPrevD = dataR;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst         = 1'b1;
        sampleValid = 1'b0;
        sample      = 16'h0000;
        repeat (2) @(negedge CLK);
        #1 rst = 1'b0;
    endtask

    // Offers one sample and holds it until the handshake completes.
    task automatic applyStimulus(input logic [15:0] v, output bit ok);
        bit r;
        sample      = v;
        sampleValid = 1'b1;
        ok          = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            r = rdy;
            @(negedge CLK);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        sampleValid = 1'b0;
    endtask

    task automatic checkFrames(input string tag, input int minFrames);
        int n;
        #1;
        checkOutput({tag, " frames"}, 32'(gotWords.size() >= minFrames), 32'd1);
        n = (gotWords.size() < expWords.size()) ? gotWords.size() : expWords.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s left%0d", tag, i), 32'(gotWords[i][31:16]), 32'(expWords[i]));
            checkOutput($sformatf("%s right%0d", tag, i), 32'(gotWords[i][15:0]), 32'(expWords[i]));
        end
        checkOutput({tag, " underrun count"}, gotUnder.size(), expUnder.size());
        n = (gotUnder.size() < expUnder.size()) ? gotUnder.size() : expUnder.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s underrun%0d", tag, i), gotUnder[i], expUnder[i]);
        end
        checkOutput({tag, " lrclk slots"}, lrErr, 0);
        checkOutput({tag, " data stable"}, stabErr, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] holdWord;
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        rstRate     = 1'b1;
        sampleValid = 1'b0;
        sample      = 16'h0000;

        // Reset values appear as soon as RST rises.
        #2 rst = 1'b1;
        #1;
        checkOutput("reset bclk", bclk, 0);
        checkOutput("reset lrclk", lrclk, 0);
        checkOutput("reset data", dataOut, 0);
        checkOutput("reset underrun", under, 0);
        checkOutput("reset ready", rdy, 1);
        @(negedge CLK);
        #1 rstRate = 1'b0;

        // Single sample 0x8001, then nothing: second load underruns.
        doReset();
        applyStimulus(16'h8001, ok);
        checkOutput("single push", ok, 1);
        for (int g = 0; g < 16 && nCyc < 2 * D - 1; g++) @(negedge CLK);
        checkOutput("single data before load", dataOut, 0);
        @(negedge CLK);
        checkOutput("single msb after load", dataOut, 1);
        checkOutput("single no underrun", under, 0);
        repeat (3 * FRAME) @(negedge CLK);
        #1;
`ifdef SID_I2S_HOLD_EN
        holdWord = 32'h80018001;
`else
        holdWord = 32'h00000000;
`endif
        checkOutput("single frame0", gotWords[0], 32'h80018001);
        checkOutput("single frame1", gotWords[1], holdWord);
        checkOutput("single underrun first", gotUnder[0], 2 * D + FRAME);
        checkOutput("single underrun second", gotUnder[1], 2 * D + 2 * FRAME);
        checkFrames("single", 2);

        // Back-pressure: five samples after the first load, the fifth waits.
        doReset();
        for (int g = 0; g < 16 && nCyc < 2 * D + 1; g++) @(negedge CLK);
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(16'(v), ok);
            checkOutput($sformatf("bp push%0d", v), ok, 1);
        end
        checkOutput("bp ready low when full", rdy, 0);
        applyStimulus(16'd5, ok);
        checkOutput("bp push5", ok, 1);
        checkOutput("bp push5 cycle", nCyc, 2 * D + FRAME + 1);
        repeat (6 * FRAME) @(negedge CLK);
        #1;
        checkOutput("bp frame0", gotWords[0], 32'h0);
        for (int v = 1; v <= 5; v++) begin
            checkOutput($sformatf("bp order%0d", v), gotWords[v], {16'(v), 16'(v)});
        end
        checkFrames("bp", 6);

        // Push lands on the edge of a load that finds the FIFO empty.
        doReset();
        for (int g = 0; g < 16 && nCyc < 2 * D - 1; g++) @(negedge CLK);
        sample      = 16'h5A5A;
        sampleValid = 1'b1;
        @(negedge CLK);
        sampleValid = 1'b0;
        checkOutput("simul underrun pulse", under, 1);
        @(negedge CLK);
        checkOutput("simul underrun one cycle", under, 0);
        repeat (2 * FRAME + FRAME / 2) @(negedge CLK);
        #1;
        checkOutput("simul frame0", gotWords[0], 32'h0);
        checkOutput("simul frame1", gotWords[1], 32'h5A5A5A5A);
        checkFrames("simul", 2);

        // Random traffic: bursts in one frame out of three.
        doReset();
        ok = 1'b0;
        for (int i = 0; i < 9 * FRAME; i++) begin
            @(negedge CLK);
            if (sampleValid && ok) sampleValid = 1'b0;
            checkOutput("rand ready", rdy, mReady);
            if (!sampleValid && ((i / FRAME) % 3) == 0 && $urandom_range(99) < 5) begin
                sample      = 16'($urandom);
                sampleValid = 1'b1;
            end
            ok = rdy;
        end
        @(negedge CLK);
        sampleValid = 1'b0;
        repeat (2 * FRAME) @(negedge CLK);
        checkFrames("rand", 9);

        // Reset mid-frame with three words queued, BCLK and DATA high.
        doReset();
        for (int v = 0; v < 4; v++) begin
            applyStimulus(16'hFFFF, ok);
            checkOutput("midrst push", ok, 1);
        end
        for (int g = 0; g < FRAME && !(bclk === 1'b1 && dataOut === 1'b1); g++) @(negedge CLK);
        checkOutput("midrst armed", {bclk, dataOut}, 2'b11);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst bclk", bclk, 0);
        checkOutput("midrst lrclk", lrclk, 0);
        checkOutput("midrst data", dataOut, 0);
        checkOutput("midrst underrun", under, 0);
        checkOutput("midrst ready", rdy, 1);
        repeat (2) @(negedge CLK);
        #1 rst = 1'b0;
        @(negedge CLK);
        checkOutput("midrst ready after release", rdy, 1);
        repeat (2 * FRAME + FRAME / 2) @(negedge CLK);
        #1;
        checkOutput("midrst frame0 abandoned", gotWords[0], 32'h0);
        checkOutput("midrst underrun at first load", gotUnder[0], 2 * D);
        checkFrames("midrst", 2);

        // Rate figures on the CLK_DIV=6 instance over ten frames.
        for (int g = 0; g < 8000 && rLCnt < 11; g++) @(negedge CLK);
        #1;
        checkOutput("rate lr periods seen", 32'(rLCnt >= 11), 1);
        checkOutput("rate first rise", rFirstB, DR);
        checkOutput("rate first lr rise", rFirstL, 32 * DR);
        checkOutput("rate bclk period", rBErr, 0);
        checkOutput("rate lrclk period", rLErr, 0);
        checkOutput("rate data stable on rise", rStab, 0);
        checkOutput("rate no underrun", rUnder, 0);
        checkOutput("rate ready full", rdyR, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
